trace_capture_buffer: RTL and testbench

- Parametrised on-chip commit-trace capture unit for the multi-issue datapath; replaces per-cycle simulation printing of instructions and ALU results with a hardware logic-analyser buffer.
- Each cycle, accepts up to LANES retired (instruction, result) pairs and stores them in a circular buffer with timestamps.
- Stops a programmable number of entries after an instruction-match trigger; the stored history is then read out one entry per request (e.g. by the LED/UART debug path).

---
 rtl/trace_capture_buffer_pkg.sv | 34 +++
 rtl/trace_capture_buffer_if.sv | 38 +++
 rtl/trace_capture_buffer_compact.sv | 30 +++
 rtl/trace_capture_buffer.sv | 123 ++++++++++++
 tb/tb_trace_capture_buffer.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/trace_capture_buffer_pkg.sv
// Shared types and entry-layout helpers for the commit-trace capture buffer.
// An entry is packed as {timestamp, lane, ins, result} with result in the LSBs.
package trace_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int RES_OFF = 0;

    function automatic int lane_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    function automatic int ins_off(input int dw);
        return dw;
    endfunction

    function automatic int lane_off(input int dw);
        return 2 * dw;
    endfunction

    function automatic int ts_off(input int lanes, input int dw);
        return 2 * dw + lane_w(lanes);
    endfunction

    function automatic int entry_w(input int lanes, input int dw, input int tsw);
        return tsw + lane_w(lanes) + 2 * dw;
    endfunction

endpackage

// File: rtl/trace_capture_buffer_if.sv
// Lane observation, trigger configuration and readout bundle of the trace buffer.
// master = debug/datapath side driving lanes and requests, slave = the buffer.
interface trace_capture_buffer_if #(
    parameter int LANES  = 2,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16
);
    import trace_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = entry_w(LANES, DATA_W, TS_W);

    logic                          arm;
    logic [LANES-1:0]              lane_valid;
    logic [LANES-1:0][DATA_W-1:0]  lane_ins;
    logic [LANES-1:0][DATA_W-1:0]  lane_result;
    logic [DATA_W-1:0]             trig_ins;
    logic [DATA_W-1:0]             trig_mask;
    logic [CW-1:0]                 post_count;
    logic                          rd_en;
    logic                          rd_valid;
    logic [EW-1:0]                 rd_data;
    logic [CW-1:0]                 count;
    logic [1:0]                    state;
    logic                          triggered;

    modport master (
        output arm, lane_valid, lane_ins, lane_result, trig_ins, trig_mask, post_count, rd_en,
        input  rd_valid, rd_data, count, state, triggered
    );

    modport slave (
        input  arm, lane_valid, lane_ins, lane_result, trig_ins, trig_mask, post_count, rd_en,
        output rd_valid, rd_data, count, state, triggered
    );

endinterface

// File: rtl/trace_capture_buffer_compact.sv
// Prefix count over valid lanes, capped at i_limit: the lowest-indexed valid
// lanes win, each gets a dense write offset relative to the write pointer.
module trace_lane_compact #(
    parameter int LANES = 2,
    parameter int CW    = 5,
    parameter int OW    = 4
) (
    input  logic [LANES-1:0]          i_valid,
    input  logic [CW-1:0]             i_limit,
    output logic [LANES-1:0]          o_we,
    output logic [LANES-1:0][OW-1:0]  o_off,
    output logic [CW-1:0]             o_total
);
    logic [CW-1:0] w_cnt;

    always_comb begin
        w_cnt = '0;
        o_we  = '0;
        o_off = '0;
        for (int i = 0; i < LANES; i++) begin
            o_off[i] = w_cnt[OW-1:0];
            if (i_valid[i] && (w_cnt < i_limit)) begin
                o_we[i] = 1'b1;
                w_cnt   = w_cnt + CW'(1);
            end
        end
        o_total = w_cnt;
    end

endmodule

// File: rtl/trace_capture_buffer.sv
// Commit-trace logic analyser: circular capture of retired lanes with
// timestamps, mask/match trigger with post-trigger window, then pop readout.
module trace_capture_buffer #(
    parameter int LANES  = 2,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst_pin,
    trace_capture_buffer_if.slave   bus
);
    import trace_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = lane_w(LANES);
    localparam int EW = entry_w(LANES, DATA_W, TS_W);

    state_t              r_state, w_next_state;
    logic [AW-1:0]       r_wptr;
    logic [CW-1:0]       r_count, r_remaining;
    logic [TS_W-1:0]     r_ts;
    logic                r_triggered, r_rd_valid;
    logic [EW-1:0]       r_rd_data;
    logic [EW-1:0]       r_mem [DEPTH];

    logic                w_hit, w_capture, w_fire, w_pop;
    logic [LANES-1:0]    w_cap_valid, w_we;
    logic [LANES-1:0][AW-1:0] w_off;
    logic [CW-1:0]       w_limit, w_total, w_left, w_count_nxt;
    logic [CW:0]         w_sum;
    logic [AW-1:0]       w_rptr;

    trace_lane_compact #(.LANES(LANES), .CW(CW), .OW(AW)) u_compact (
        .i_valid (w_cap_valid),
        .i_limit (w_limit),
        .o_we    (w_we),
        .o_off   (w_off),
        .o_total (w_total)
    );

    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < LANES; i++)
            if (bus.lane_valid[i] && (((bus.lane_ins[i] ^ bus.trig_ins) & bus.trig_mask) == '0))
                w_hit = 1'b1;
    end

    // Outside the trigger cycle and POST the limit is never binding.
    assign w_capture   = !bus.arm && (r_state == ARMED || r_state == POST);
    assign w_fire      = !bus.arm && (r_state == ARMED) && w_hit;
    assign w_limit     = (r_state == POST) ? r_remaining : (w_fire ? bus.post_count : CW'(LANES));
    assign w_cap_valid = w_capture ? bus.lane_valid : '0;
    assign w_left      = w_limit - w_total;
    assign w_sum       = {1'b0, r_count} + {1'b0, w_total};
    assign w_count_nxt = (w_sum > (CW+1)'(DEPTH)) ? CW'(DEPTH) : w_sum[CW-1:0];
    assign w_pop       = !bus.arm && (r_state == DONE) && bus.rd_en && (r_count != '0);
    // Oldest entry sits count slots behind the write pointer; count=DEPTH wraps to wptr.
    assign w_rptr      = r_wptr - r_count[AW-1:0];

    always_comb begin
        w_next_state = r_state;
        if (bus.arm)
            w_next_state = ARMED;
        else begin
            case (r_state)
                ARMED:   if (w_fire) w_next_state = (w_left == '0) ? DONE : POST;
                POST:    if (w_left == '0) w_next_state = DONE;
                default: w_next_state = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_pin) begin
        if (!rst_pin) r_state <= IDLE;
        else          r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge rst_pin) begin
        if (!rst_pin) begin
            r_wptr      <= '0;
            r_count     <= '0;
            r_remaining <= '0;
            r_ts        <= '0;
            r_triggered <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
        end else begin
            r_ts <= r_ts + TS_W'(1);
            if (bus.arm) begin
                r_count     <= '0;
                r_triggered <= 1'b0;
                r_rd_valid  <= 1'b0;
            end else begin
                r_rd_valid <= w_pop;
                if (w_pop) begin
                    r_rd_data <= r_mem[w_rptr];
                    r_count   <= r_count - CW'(1);
                end
                if (w_capture) begin
                    r_wptr  <= r_wptr + w_total[AW-1:0];
                    r_count <= w_count_nxt;
                end
                if (w_fire) r_triggered <= 1'b1;
                if (w_fire || r_state == POST) r_remaining <= w_left;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++)
            if (w_we[i])
                r_mem[r_wptr + w_off[i]] <= {r_ts, LW'(i), bus.lane_ins[i], bus.lane_result[i]};
    end

    assign bus.rd_valid  = r_rd_valid;
    assign bus.rd_data   = r_rd_data;
    assign bus.count     = r_count;
    assign bus.state     = r_state;
    assign bus.triggered = r_triggered;

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Directed bench for trace_capture_buffer: stimulus pushes hand-derived entries
// into a queue, a negedge monitor pops and compares every rd_valid pulse.
module tb_trace_capture_buffer;

    localparam logic [31:0] RK = 32'hA5A5_5A5A;

    logic clk = 1'b0;
    logic rst_pin = 1'b0;
    logic [15:0] tb_ts;
    int n_cmp = 0;
    int n_bad = 0;
    int n_pop = 0;
    logic [80:0] exp_q[$];
    logic [80:0] exp_e;

    always #5 clk = ~clk;

    trace_capture_buffer_if #(.LANES(2), .DATA_W(32), .DEPTH(16), .TS_W(16)) bus ();

    trace_capture_buffer #(.LANES(2), .DATA_W(32), .DEPTH(16), .TS_W(16)) dut (
        .clk     (clk),
        .rst_pin (rst_pin),
        .bus     (bus)
    );

    // Reference free-running timestamp.
    always @(posedge clk or negedge rst_pin)
        if (!rst_pin) tb_ts <= '0;
        else          tb_ts <= tb_ts + 16'd1;

    function automatic logic [80:0] mk(input logic [15:0] ts, input logic ln, input logic [31:0] ins);
        return {ts, ln, ins, ins ^ RK};
    endfunction

    always @(negedge clk) begin
        if (rst_pin && bus.rd_valid) begin
            n_cmp++;
            n_pop++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL pop%0d: unexpected entry %h, none required", n_pop, bus.rd_data);
            end else begin
                exp_e = exp_q.pop_front();
                if (bus.rd_data !== exp_e) begin
                    n_bad++;
                    $display("FAIL pop%0d: got %h required %h", n_pop, bus.rd_data, exp_e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cap(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                       input bit p0, input bit p1);
        if (p0) exp_q.push_back(mk(tb_ts, 1'b0, i0));
        if (p1) exp_q.push_back(mk(tb_ts, 1'b1, i1));
        bus.lane_valid     = v;
        bus.lane_ins[0]    = i0;
        bus.lane_ins[1]    = i1;
        bus.lane_result[0] = i0 ^ RK;
        bus.lane_result[1] = i1 ^ RK;
        step();
        bus.lane_valid = '0;
    endtask

    task automatic do_arm();
        bus.arm = 1'b1;
        step();
        bus.arm = 1'b0;
    endtask

    task automatic pop(input int n);
        bus.rd_en = 1'b1;
        repeat (n) step();
        bus.rd_en = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.arm = 0; bus.lane_valid = '0; bus.lane_ins = '0; bus.lane_result = '0;
        bus.trig_ins = 32'hFFFF_FFFF; bus.trig_mask = 32'hFFFF_FFFF;
        bus.post_count = 5'd0; bus.rd_en = 0;
        #12;
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 0);
        chk("rst_triggered", 32'(bus.triggered), 0);
        chk("rst_rd_data", bus.rd_data[31:0], 0);
        @(negedge clk); rst_pin = 1'b1;
        step();

        // IDLE ignores lanes, even a trigger match.
        cap(2'b11, 32'hFFFF_FFFF, 32'h1, 0, 0);
        chk("idle_count", 32'(bus.count), 0);
        chk("idle_state", 32'(bus.state), 0);

        // Basic two-lane capture.
        bus.trig_ins = 32'h0060_0093; bus.trig_mask = 32'hFFFF_FFFF; bus.post_count = 5'd2;
        do_arm();
        chk("arm_state", 32'(bus.state), 1);
        bus.rd_en = 1'b1;
        cap(2'b11, 32'h0010_0093, 32'h0020_0093, 1, 1);
        bus.rd_en = 1'b0;
        chk("armed_rd_valid", 32'(bus.rd_valid), 0);
        chk("armed_count", 32'(bus.count), 2);
        cap(2'b11, 32'h0030_0093, 32'h0040_0093, 1, 1);
        cap(2'b11, 32'h0050_0093, 32'h0060_0093, 1, 1);
        chk("basic_state", 32'(bus.state), 3);
        chk("basic_count", 32'(bus.count), 6);
        chk("basic_trig", 32'(bus.triggered), 1);
        pop(6);
        chk("basic_drained", 32'(bus.count), 0);
        chk("basic_queue", exp_q.size(), 0);
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        chk("empty_rd_valid", 32'(bus.rd_valid), 0);
        chk("empty_count", 32'(bus.count), 0);

        // Masked opcode trigger, then limit split in POST.
        bus.trig_ins = 32'h0000_0063; bus.trig_mask = 32'h0000_007F; bus.post_count = 5'd3;
        do_arm();
        chk("rearm_trig", 32'(bus.triggered), 0);
        cap(2'b11, 32'h0000_0013, 32'h0020_8463, 1, 1);
        chk("mask_trig", 32'(bus.triggered), 1);
        chk("mask_state", 32'(bus.state), 2);
        cap(2'b11, 32'h00A0_0093, 32'h00B0_0093, 1, 0);
        chk("split_state", 32'(bus.state), 3);
        chk("split_count", 32'(bus.count), 3);
        pop(3);
        chk("split_queue", exp_q.size(), 0);

        // Overflow in ARMED: 22 entries total, oldest kept is #7.
        bus.trig_ins = 32'hDEAD_0000; bus.trig_mask = 32'hFFFF_FFFF; bus.post_count = 5'd2;
        do_arm();
        for (int k = 1; k <= 20; k++)
            cap(2'b01, 32'h0000_1000 + 32'(k), 32'h0, k >= 7, 0);
        chk("wrap_armed_count", 32'(bus.count), 16);
        cap(2'b01, 32'hDEAD_0000, 32'h0, 1, 0);
        chk("wrap_post_state", 32'(bus.state), 2);
        cap(2'b01, 32'h2222_0000, 32'h0, 1, 0);
        chk("wrap_state", 32'(bus.state), 3);
        chk("wrap_count", 32'(bus.count), 16);
        bus.rd_en = 1'b1;
        repeat (14) step();
        chk("wrap_partial_count", 32'(bus.count), 2);
        // arm beats rd_en in the same cycle.
        bus.arm = 1'b1;
        step();
        bus.arm = 1'b0; bus.rd_en = 1'b0;
        chk("armrd_state", 32'(bus.state), 1);
        chk("armrd_count", 32'(bus.count), 0);
        chk("armrd_rd_valid", 32'(bus.rd_valid), 0);
        chk("armrd_queue_left", exp_q.size(), 2);
        exp_q.delete();

        // Asynchronous reset in the middle of POST.
        bus.post_count = 5'd5;
        cap(2'b01, 32'hDEAD_0000, 32'h0, 0, 0);
        chk("pre_rst_state", 32'(bus.state), 2);
        #3;
        rst_pin = 1'b0;
        #1;
        chk("async_state", 32'(bus.state), 0);
        chk("async_count", 32'(bus.count), 0);
        chk("async_trig", 32'(bus.triggered), 0);
        chk("async_rd_valid", 32'(bus.rd_valid), 0);
        @(negedge clk); rst_pin = 1'b1;
        step();
        chk("final_queue", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
